// File: rtl/ls_sweep_ctrl.sv
// Test sequencer for the LS_CNT error-counter datapath: clear, settle, measure, capture,
// optionally repeated for all four CLK_CTRL sample-delay settings, with best-setting selection.
module ls_sweep_ctrl #(
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned LAT_CYC    = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic        SWEEP_EN,
    input  logic [1:0]  CLK_CTRL_INIT,
    input  logic [31:0] WIN_LEN,
    input  logic [31:0] ERR_CNT,
    output logic        CNT_RST,
    output logic [1:0]  CLK_CTRL,
    output logic        BUSY,
    output logic        DONE,
    output logic        ABORTED,
    output logic        CFG_ERR,
    output logic [31:0] RES0,
    output logic [31:0] RES1,
    output logic [31:0] RES2,
    output logic [31:0] RES3,
    output logic [3:0]  RES_VLD,
    output logic [1:0]  BEST_SEL
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StSettle,
        StRun,
        StLat,
        StCap,
        StNext
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_dur;
    logic        w_cnt_end;
    logic        r_sweep;
    logic [31:0] r_win;
    logic [1:0]  r_clk_ctrl;
    logic [1:0]  w_clk_nxt;
    logic        r_cnt_rst;
    logic        r_busy;
    logic        r_done;
    logic        r_aborted;
    logic        r_cfg_err;
    logic [31:0] r_res [4];
    logic [3:0]  r_vld;
    logic [1:0]  r_best;
    logic [1:0]  w_best;
    logic [31:0] w_best_min;
    logic        w_best_found;
    logic        w_start;
    logic        w_cfg_rej;
    logic        w_cap;
    logic        w_abort;
    logic        w_cnt_rst_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    // State register together with the registered outputs and captured results.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_sweep    <= 1'b0;
            r_win      <= '0;
            r_clk_ctrl <= '0;
            r_cnt_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_vld      <= '0;
            r_best     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk_ctrl <= w_clk_nxt;
            r_cnt_rst  <= w_cnt_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_aborted  <= w_abort;
            r_cfg_err  <= w_cfg_rej;
            if (r_vld != 4'd0) begin
                r_best <= w_best;
            end
            if (w_start) begin
                r_sweep <= SWEEP_EN;
                r_win   <= WIN_LEN;
                r_vld   <= '0;
            end else if (w_cap) begin
                r_res[r_clk_ctrl] <= ERR_CNT;
                r_vld[r_clk_ctrl] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_cfg_rej   = 1'b0;
        w_cap       = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            StClr:    w_dur = RST_CYC - 32'd1;
            StSettle: w_dur = SETTLE_CYC - 32'd1;
            StRun:    w_dur = r_win - 32'd1;
            StLat:    w_dur = LAT_CYC - 32'd1;
            default:  w_dur = '0;
        endcase
        w_cnt_end = (r_cnt == w_dur);
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    if (WIN_LEN == 32'd0) begin
                        w_cfg_rej = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StClr;
                    end
                end
            end
            StClr, StSettle, StRun, StLat: begin
                if (w_cnt_end) begin
                    w_cnt_nxt = '0;
                    unique case (r_state)
                        StClr:    w_state_nxt = StSettle;
                        StSettle: w_state_nxt = StRun;
                        StRun:    w_state_nxt = StLat;
                        default:  w_state_nxt = StCap;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            StCap: begin
                w_cap       = 1'b1;
                w_state_nxt = (r_sweep && (r_clk_ctrl != 2'd3)) ? StNext : StIdle;
            end
            StNext:  w_state_nxt = StClr;
            default: w_state_nxt = StIdle;
        endcase
        // Abort pre-empts everything, including a capture in progress.
        if ((r_state != StIdle) && ABORT) begin
            w_abort     = 1'b1;
            w_cap       = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
        end
    end

    always_comb begin
        w_cnt_rst_nxt = (w_state_nxt == StClr);
        w_busy_nxt    = (w_state_nxt != StIdle);
        w_done_nxt    = (r_state == StCap) && (w_state_nxt == StIdle) && !w_abort;
        w_clk_nxt     = r_clk_ctrl;
        if (w_start) begin
            w_clk_nxt = SWEEP_EN ? 2'd0 : CLK_CTRL_INIT;
        end else if ((r_state == StNext) && !w_abort) begin
            w_clk_nxt = r_clk_ctrl + 2'd1;
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best       = r_best;
        w_best_min   = '0;
        w_best_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_vld[i] && (!w_best_found || (r_res[i] < w_best_min))) begin
                w_best       = 2'(i);
                w_best_min   = r_res[i];
                w_best_found = 1'b1;
            end
        end
    end

    assign CNT_RST  = r_cnt_rst;
    assign CLK_CTRL = r_clk_ctrl;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ABORTED  = r_aborted;
    assign CFG_ERR  = r_cfg_err;
    assign RES0     = r_res[0];
    assign RES1     = r_res[1];
    assign RES2     = r_res[2];
    assign RES3     = r_res[3];
    assign RES_VLD  = r_vld;
    assign BEST_SEL = r_best;

endmodule
